// File: rtl/read_iq_multi_pkg.sv
// Shared types and helpers for the multi-pair IQ reader.
package read_iq_multi_pkg;

  localparam int unsigned QUANT_BITS_DEFAULT = 10;

  typedef enum logic [0:0] {LOAD, EMIT} state_t;

  // Sign-extend a comp_width-bit value (held in the low bits) to 64 bits, then shift left.
  function automatic logic [63:0] quantize(input logic [63:0] comp,
                                           input int unsigned comp_width,
                                           input int unsigned quant_bits);
    logic signed [63:0] ext;
    ext = $signed(comp << (64 - comp_width)) >>> (64 - comp_width);
    return ext <<< quant_bits;
  endfunction

endpackage

// File: rtl/read_iq_multi_unpack.sv
// Selects pair idx from a packed word, optionally byte-swaps, and quantizes I and Q.
module read_iq_multi_unpack
  import read_iq_multi_pkg::*;
#(
  parameter int unsigned IN_WIDTH       = 32,
  parameter int unsigned COMP_WIDTH     = 16,
  parameter int unsigned PAIRS_PER_WORD = 1,
  parameter int unsigned OUT_WIDTH      = 32,
  parameter int unsigned QUANT_BITS     = QUANT_BITS_DEFAULT,
  parameter int unsigned IDX_WIDTH      = 1
) (
  input  logic [IN_WIDTH-1:0]         word,
  input  logic [IDX_WIDTH-1:0]        idx,
  input  logic                        swap,
  output logic signed [OUT_WIDTH-1:0] i_sample,
  output logic signed [OUT_WIDTH-1:0] q_sample
);

  localparam int unsigned PairW  = 2 * COMP_WIDTH;
  localparam int unsigned NBytes = COMP_WIDTH / 8;

  logic [PairW-1:0]      pair;
  logic [COMP_WIDTH-1:0] i_raw, q_raw, i_ord, q_ord;

  always_comb begin
    pair = '0;
    for (int k = 0; k < PAIRS_PER_WORD; k++) begin
      if (idx == IDX_WIDTH'(k)) pair = word[k*PairW +: PairW];
    end
    q_raw = pair[COMP_WIDTH-1:0];
    i_raw = pair[PairW-1:COMP_WIDTH];
    i_ord = i_raw;
    q_ord = q_raw;
    if (swap) begin
      for (int b = 0; b < NBytes; b++) begin
        i_ord[b*8 +: 8] = i_raw[(NBytes-1-b)*8 +: 8];
        q_ord[b*8 +: 8] = q_raw[(NBytes-1-b)*8 +: 8];
      end
    end
    i_sample = OUT_WIDTH'(quantize(64'(i_ord), COMP_WIDTH, QUANT_BITS));
    q_sample = OUT_WIDTH'(quantize(64'(q_ord), COMP_WIDTH, QUANT_BITS));
  end

endmodule

// File: rtl/read_iq_multi.sv
// Multi-pair IQ reader: pops packed words, streams one (I,Q) pair per cycle to two FIFOs.
// Optional READ_IQ_STATS_EN adds pair_count and stall_cycles counters.
module read_iq_multi
  import read_iq_multi_pkg::*;
#(
  parameter int unsigned IN_WIDTH       = 32,
  parameter int unsigned COMP_WIDTH     = 16,
  parameter int unsigned PAIRS_PER_WORD = 1,
  parameter int unsigned OUT_WIDTH      = 32,
  parameter int unsigned QUANT_BITS     = QUANT_BITS_DEFAULT
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        swap_bytes,
  output logic                        in_rd_en,
  input  logic                        in_empty,
  input  logic [IN_WIDTH-1:0]         in_dout,
  output logic                        out_wr_en,
  input  logic                        out_full,
  output logic signed [OUT_WIDTH-1:0] out_din,
  output logic                        out_wr_en_2,
  input  logic                        out_full_2,
  output logic signed [OUT_WIDTH-1:0] out_din_2
`ifdef READ_IQ_STATS_EN
  ,
  output logic [31:0]                 pair_count,
  output logic [31:0]                 stall_cycles
`endif
);

  localparam int unsigned IdxW = (PAIRS_PER_WORD > 1) ? $clog2(PAIRS_PER_WORD) : 1;

  if (IN_WIDTH != PAIRS_PER_WORD * 2 * COMP_WIDTH) begin : g_bad_in_width
    $error("IN_WIDTH must equal PAIRS_PER_WORD*2*COMP_WIDTH");
  end
  if (COMP_WIDTH == 0 || COMP_WIDTH % 8 != 0) begin : g_bad_comp_width
    $error("COMP_WIDTH must be a non-zero multiple of 8");
  end
  if (PAIRS_PER_WORD < 1 || PAIRS_PER_WORD > 8) begin : g_bad_pairs
    $error("PAIRS_PER_WORD must be in 1..8");
  end
  if (OUT_WIDTH < COMP_WIDTH + QUANT_BITS || OUT_WIDTH > 64) begin : g_bad_out_width
    $error("OUT_WIDTH must be >= COMP_WIDTH+QUANT_BITS and <= 64");
  end

  state_t                state;
  logic [IdxW-1:0]       idx;
  logic [IN_WIDTH-1:0]   word_reg;
  logic                  swap_reg;
  logic                  write, last, blocked;
  logic signed [OUT_WIDTH-1:0] i_sample, q_sample;

  read_iq_multi_unpack #(
    .IN_WIDTH      (IN_WIDTH),
    .COMP_WIDTH    (COMP_WIDTH),
    .PAIRS_PER_WORD(PAIRS_PER_WORD),
    .OUT_WIDTH     (OUT_WIDTH),
    .QUANT_BITS    (QUANT_BITS),
    .IDX_WIDTH     (IdxW)
  ) u_unpack (
    .word    (word_reg),
    .idx     (idx),
    .swap    (swap_reg),
    .i_sample(i_sample),
    .q_sample(q_sample)
  );

  assign last    = (idx == IdxW'(PAIRS_PER_WORD - 1));
  assign blocked = out_full | out_full_2;

  // Handshakes are combinational so a pop and the final pair write share a cycle.
  always_comb begin
    in_rd_en = 1'b0;
    write    = 1'b0;
    if (reset) begin
      case (state)
        LOAD:    in_rd_en = !in_empty;
        EMIT: begin
          if (!blocked) begin
            write    = 1'b1;
            in_rd_en = last && !in_empty;
          end
        end
        default: ;
      endcase
    end
    out_wr_en   = write;
    out_wr_en_2 = write;
    out_din     = write ? i_sample : '0;
    out_din_2   = write ? q_sample : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= LOAD;
      idx      <= '0;
      word_reg <= '0;
      swap_reg <= 1'b0;
    end else if (in_rd_en) begin
      word_reg <= in_dout;
      swap_reg <= swap_bytes;
      idx      <= '0;
      state    <= EMIT;
    end else if (write) begin
      if (!last) idx <= idx + IdxW'(1);
      else       state <= LOAD;
    end
  end

`ifdef READ_IQ_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      pair_count   <= '0;
      stall_cycles <= '0;
    end else begin
      if (write) pair_count <= pair_count + 32'd1;
      if (state == EMIT && blocked && stall_cycles != '1) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_read_iq_multi.sv
// Self-checking bench for read_iq_multi (two pairs per word) with a queue-based reference model.
module tb_read_iq_multi;

  localparam int unsigned IW  = 64;
  localparam int unsigned CW  = 16;
  localparam int unsigned PPW = 2;
  localparam int unsigned OW  = 32;
  localparam int unsigned QB  = 10;

  logic clock = 1'b0, reset = 1'b0, swap_bytes = 1'b0;
  logic in_empty, out_full = 1'b0, out_full_2 = 1'b0;
  logic [IW-1:0] in_dout;
  logic in_rd_en, out_wr_en, out_wr_en_2;
  logic signed [OW-1:0] out_din, out_din_2;
`ifdef READ_IQ_STATS_EN
  logic [31:0] pair_count, stall_cycles;
`endif

  read_iq_multi #(
    .IN_WIDTH      (IW),
    .COMP_WIDTH    (CW),
    .PAIRS_PER_WORD(PPW),
    .OUT_WIDTH     (OW),
    .QUANT_BITS    (QB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .swap_bytes (swap_bytes),
    .in_rd_en   (in_rd_en),
    .in_empty   (in_empty),
    .in_dout    (in_dout),
    .out_wr_en  (out_wr_en),
    .out_full   (out_full),
    .out_din    (out_din),
    .out_wr_en_2(out_wr_en_2),
    .out_full_2 (out_full_2),
    .out_din_2  (out_din_2)
`ifdef READ_IQ_STATS_EN
    ,
    .pair_count  (pair_count),
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int model_pairs = 0, model_stalls = 0;
  logic [IW-1:0] in_q[$];
  logic [63:0]   exp_q[$];
  logic [63:0]   wr_log[$];
  int            wr_cyc[$], rd_cyc[$];
  logic [IW-1:0] last_rd_word;
  logic hide_in = 1'b0, rand_mode = 1'b0;
  logic saw_rd, saw_wr, saw_reset, saw_swap;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference conversion of one raw 16-bit component, done with integer arithmetic.
  function automatic logic [31:0] ref_comp(input int c, input logic sw);
    int v;
    v = sw ? (((c & 255) << 8) | ((c >> 8) & 255)) : c;
    if (v >= 32768) v = v - 65536;
    return 32'(v * 1024);
  endfunction

  function automatic void push_word(input logic [IW-1:0] w, input logic sw);
    for (int k = 0; k < PPW; k++) begin
      int hi, lo;
      lo = int'((w >> (32 * k)) & 64'hFFFF);
      hi = int'((w >> (32 * k + 16)) & 64'hFFFF);
      exp_q.push_back({ref_comp(hi, sw), ref_comp(lo, sw)});
    end
  endfunction

  task automatic drive();
    in_empty = hide_in || (in_q.size() == 0);
    in_dout  = (in_q.size() != 0) ? in_q[0] : {$urandom, $urandom};
  endtask

  task automatic cycle();
    cyc++;
    @(negedge clock);
    saw_rd    = in_rd_en;
    saw_wr    = out_wr_en;
    saw_reset = reset;
    saw_swap  = swap_bytes;
    check("rd_while_empty", 64'(in_rd_en & in_empty), 64'd0);
    check("wr_pair_sync", 64'(out_wr_en_2), 64'(out_wr_en));
    if (reset && exp_q.size() != 0 && (out_full || out_full_2)) model_stalls++;
    if (in_rd_en) begin
      rd_cyc.push_back(cyc);
      last_rd_word = in_dout;
    end
    if (out_wr_en) begin
      wr_log.push_back({out_din, out_din_2});
      wr_cyc.push_back(cyc);
      check("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("pair_value", {out_din, out_din_2}, exp_q[0]);
    end else begin
      check("idle_din_zero", {out_din, out_din_2}, 64'd0);
    end
    @(posedge clock);
    #1;
    if (!saw_reset) begin
      exp_q.delete();
      model_pairs  = 0;
      model_stalls = 0;
    end else begin
      if (saw_wr) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        model_pairs++;
      end
      if (saw_rd && in_q.size() != 0) push_word(in_q.pop_front(), saw_swap);
    end
    if (rand_mode) begin
      hide_in    = ~hide_in;
      out_full   = ($urandom_range(3) == 0);
      out_full_2 = ($urandom_range(3) == 0);
      swap_bytes = 1'($urandom_range(1));
    end
    drive();
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_within_budget", 64'(n < budget), 64'd1);
    cycle();
    cycle();
  endtask

  task automatic clear_logs();
    wr_log.delete();
    wr_cyc.delete();
    rd_cyc.delete();
  endtask

  initial begin
    logic [IW-1:0] w0, w1;
    int n;
    drive();
    // Reset: no handshakes, outputs zero.
    cycle();
    check("reset_rd", 64'(saw_rd), 64'd0);
    cycle();
    check("reset_wr", 64'(saw_wr), 64'd0);
    reset = 1'b1;
    cycle();
    check("idle_no_rd", 64'(saw_rd), 64'd0);
`ifdef READ_IQ_STATS_EN
    check("stats_reset_pairs", 64'(pair_count), 64'd0);
    check("stats_reset_stalls", 64'(stall_cycles), 64'd0);
`endif

    // Byte swap enabled.
    clear_logs();
    swap_bytes = 1'b1;
    in_q.push_back(64'h0000FFFF_01020304);
    drive();
    run_idle(20);
    check("swap1_writes", 64'(wr_log.size()), 64'd2);
    check("swap1_p0", wr_log[0], {32'd525312, 32'd1051648});
    check("swap1_p1", wr_log[1], {32'd0, 32'hFFFFFC00});

    // Natural byte order.
    clear_logs();
    swap_bytes = 1'b0;
    in_q.push_back(64'h0000FFFF_01020304);
    drive();
    run_idle(20);
    check("swap0_p0", wr_log[0], {32'd264192, 32'd790528});
    check("swap0_p1", wr_log[1], {32'd0, 32'hFFFFFC00});

    // Two words back to back: no bubble, pop lands on w0p1.
    clear_logs();
    in_q.push_back({$urandom, $urandom});
    in_q.push_back({$urandom, $urandom});
    drive();
    run_idle(20);
    check("b2b_writes", 64'(wr_cyc.size()), 64'd4);
    check("b2b_pops", 64'(rd_cyc.size()), 64'd2);
    if (wr_cyc.size() == 4 && rd_cyc.size() == 2) begin
      check("b2b_latency", 64'(wr_cyc[0]), 64'(rd_cyc[0] + 1));
      check("b2b_span", 64'(wr_cyc[3]), 64'(wr_cyc[0] + 3));
      check("b2b_pop_on_w0p1", 64'(rd_cyc[1]), 64'(wr_cyc[1]));
    end

    // Stall on Q FIFO for three cycles mid-word.
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    clear_logs();
    in_q.push_back({$urandom, $urandom});
    drive();
    n = 0;
    while (wr_log.size() < 1 && n < 10) begin
      cycle();
      n++;
    end
    check("stall_first_write_seen", 64'(wr_log.size()), 64'd1);
    out_full_2 = 1'b1;
    repeat (3) cycle();
    check("stall_no_writes", 64'(wr_log.size()), 64'd1);
    out_full_2 = 1'b0;
    cycle();
    check("stall_resume_write", 64'(saw_wr), 64'd1);
    run_idle(20);
    check("stall_total_writes", 64'(wr_log.size()), 64'd2);
`ifdef READ_IQ_STATS_EN
    check("stats_stall3", 64'(stall_cycles), 64'd3);
    check("stats_pairs2", 64'(pair_count), 64'd2);
`endif

    // Reset after w0p0: w0p1 is dropped, w1 is the next pop.
    clear_logs();
    w0 = {$urandom, $urandom};
    w1 = {$urandom, $urandom};
    in_q.push_back(w0);
    in_q.push_back(w1);
    drive();
    n = 0;
    while (wr_log.size() < 1 && n < 10) begin
      cycle();
      n++;
    end
    reset = 1'b0;
    cycle();
    check("rst_mid_no_write", 64'(saw_wr), 64'd0);
    check("rst_mid_no_rd", 64'(saw_rd), 64'd0);
`ifdef READ_IQ_STATS_EN
    check("stats_rst_pairs0", 64'(pair_count), 64'd0);
`endif
    reset = 1'b1;
    cycle();
    check("rst_load_pop", 64'(saw_rd), 64'd1);
    check("rst_popped_w1", last_rd_word, w1);
    run_idle(20);
    check("rst_total_writes", 64'(wr_log.size()), 64'd3);

    // Randomized traffic with toggling empty and random back-pressure.
    clear_logs();
    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) in_q.push_back({$urandom, $urandom});
    drive();
    run_idle(3000);
    rand_mode  = 1'b0;
    hide_in    = 1'b0;
    out_full   = 1'b0;
    out_full_2 = 1'b0;
    drive();
    run_idle(20);
    check("rand_total_writes", 64'(wr_log.size()), 64'(40 * PPW));
`ifdef READ_IQ_STATS_EN
    check("stats_rand_pairs", 64'(pair_count), 64'(model_pairs));
    check("stats_rand_stalls", 64'(stall_cycles), 64'(model_stalls));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
